traffic_ctrl_2way: RTL and testbench

- Parametrised two-direction (main/side) intersection light controller; successor to the single-approach light sequencer.
- Phase timing advances on a tick-enable input, so clk may be fast.
- Adds all-red clearance phases, programmable phase lengths, and per-direction red-light violation monitoring (camera pulse plus saturating violation counter).
- Sits between the board tick divider and the lamp/camera drivers.

---
 rtl/traffic_pkg.sv | 48 ++++
 rtl/traffic_vio_mon.sv | 46 ++++
 rtl/traffic_ctrl_2way.sv | 151 +++++++++++++++
 tb/tb_traffic_ctrl_2way.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp codes and state helpers for the two-way
// intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Fixed successor in the six-phase ring.
  function automatic state_t next_state(input state_t st);
    state_t nxt;
    case (st)
      MAIN_G:  nxt = MAIN_Y;
      MAIN_Y:  nxt = RED1;
      RED1:    nxt = SIDE_G;
      SIDE_G:  nxt = SIDE_Y;
      SIDE_Y:  nxt = RED2;
      RED2:    nxt = MAIN_G;
      default: nxt = MAIN_G;
    endcase
    return nxt;
  endfunction

  // Returns {main_lt, side_lt}; unknown encodings fall back to all-red.
  function automatic logic [5:0] state_lamps(input state_t st);
    logic [5:0] lt;
    case (st)
      MAIN_G:  lt = {LT_GRN, LT_RED};
      MAIN_Y:  lt = {LT_YEL, LT_RED};
      RED1:    lt = {LT_RED, LT_RED};
      SIDE_G:  lt = {LT_RED, LT_GRN};
      SIDE_Y:  lt = {LT_RED, LT_YEL};
      RED2:    lt = {LT_RED, LT_RED};
      default: lt = {LT_RED, LT_RED};
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/traffic_vio_mon.sv
// Red-light violation monitor for one approach: rising-edge detect against the
// registered red lamp, one-clk camera pulse and saturating violation counter.
module traffic_vio_mon #(
  parameter int VIO_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sensor,
  input  logic             i_red,
  input  logic             i_clr,
  output logic             o_camera,
  output logic [VIO_W-1:0] o_cnt
);

  localparam logic [VIO_W-1:0] CNT_MAX = {VIO_W{1'b1}};

  logic             r_s_q;
  logic             r_camera;
  logic [VIO_W-1:0] r_cnt;
  logic             w_vio;

  assign w_vio = i_sensor & ~r_s_q & i_red;

  // Sensor history, camera pulse and counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q    <= 1'b0;
      r_camera <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s_q    <= i_sensor;
      r_camera <= w_vio;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (w_vio && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + {{(VIO_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign o_camera = r_camera;
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-direction light controller with all-red clearance and violation monitors.
// Optional pedestrian preemption of main green is enabled by macro PED_REQ_EN.
module traffic_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MAIN_GREEN_T = 9,
  parameter int SIDE_GREEN_T = 6,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int VIO_W        = 4,
  parameter int MIN_GREEN_T  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [1:0]       s,
  input  logic             vio_clr,
  output logic [2:0]       main_lt,
  output logic [2:0]       side_lt,
  output logic [1:0]       camera,
  output logic [VIO_W-1:0] vio_cnt0,
  output logic [VIO_W-1:0] vio_cnt1,
  output logic [2:0]       phase,
  input  logic             ped_req,
  output logic             ped_walk
);

  function automatic logic [CNT_W-1:0] phase_load(input state_t st);
    logic [CNT_W-1:0] ld;
    case (st)
      MAIN_G:         ld = CNT_W'(MAIN_GREEN_T - 1);
      MAIN_Y, SIDE_Y: ld = CNT_W'(YELLOW_T - 1);
      RED1, RED2:     ld = CNT_W'(ALLRED_T - 1);
      SIDE_G:         ld = CNT_W'(SIDE_GREEN_T - 1);
      default:        ld = CNT_W'(MAIN_GREEN_T - 1);
    endcase
    return ld;
  endfunction

  state_t           r_state;
  state_t           w_nxt_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_nxt_timer;
  logic [2:0]       r_main_lt;
  logic [2:0]       r_side_lt;
  logic             r_ped_walk;
  logic             w_ped_cut;
  logic [5:0]       w_lamps;

`ifdef PED_REQ_EN
  logic r_ped_latch;
  logic w_enter_side;

  assign w_ped_cut    = (r_state == MAIN_G) && r_ped_latch &&
                        (r_timer <= CNT_W'(MAIN_GREEN_T - 1 - MIN_GREEN_T));
  assign w_enter_side = (w_nxt_state == SIDE_G) && (r_state != SIDE_G);

  // Sticky pedestrian request, consumed when side green begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ped_latch <= 1'b0;
      r_ped_walk  <= 1'b0;
    end else begin
      r_ped_latch <= (r_ped_latch & ~w_enter_side) | ped_req;
      r_ped_walk  <= (r_state == SIDE_G);
    end
  end
`else
  logic w_unused;

  assign w_ped_cut = 1'b0;
  assign w_unused  = ped_req & (MIN_GREEN_T > 0);

  // Walk lamp stays dark when preemption is not built in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ped_walk <= 1'b0;
    end else begin
      r_ped_walk <= 1'b0;
    end
  end
`endif

  // Phase state and timer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MAIN_G;
      r_timer <= CNT_W'(MAIN_GREEN_T - 1);
    end else begin
      r_state <= w_nxt_state;
      r_timer <= w_nxt_timer;
    end
  end

  // Next phase/timer: advance only on tick, when expired or preempted.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    if (tick) begin
      if ((r_timer == '0) || w_ped_cut) begin
        w_nxt_state = next_state(r_state);
        w_nxt_timer = phase_load(next_state(r_state));
      end else begin
        w_nxt_timer = r_timer - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_nxt_state = r_state;
      w_nxt_timer = r_timer;
    end
  end

  assign w_lamps = state_lamps(r_state);

  // Lamps follow the state one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_lt <= LT_GRN;
      r_side_lt <= LT_RED;
    end else begin
      r_main_lt <= w_lamps[5:3];
      r_side_lt <= w_lamps[2:0];
    end
  end

  traffic_vio_mon #(.VIO_W(VIO_W)) u_vio_main (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (s[0]),
    .i_red    (r_main_lt[2]),
    .i_clr    (vio_clr),
    .o_camera (camera[0]),
    .o_cnt    (vio_cnt0)
  );

  traffic_vio_mon #(.VIO_W(VIO_W)) u_vio_side (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (s[1]),
    .i_red    (r_side_lt[2]),
    .i_clr    (vio_clr),
    .o_camera (camera[1]),
    .o_cnt    (vio_cnt1)
  );

  assign main_lt  = r_main_lt;
  assign side_lt  = r_side_lt;
  assign phase    = r_state;
  assign ped_walk = r_ped_walk;

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Directed self-checking bench for traffic_ctrl_2way in its default build.
module tb_traffic_ctrl_2way;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [1:0] s;
  logic       vio_clr;
  logic       ped_req;
  logic [2:0] main_lt;
  logic [2:0] side_lt;
  logic [1:0] camera;
  logic [3:0] vio_cnt0;
  logic [3:0] vio_cnt1;
  logic [2:0] phase;
  logic       ped_walk;

  int checks   = 0;
  int failures = 0;
  int tcount   = 0;
  int e_prev;

  traffic_ctrl_2way dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .s        (s),
    .vio_clr  (vio_clr),
    .main_lt  (main_lt),
    .side_lt  (side_lt),
    .camera   (camera),
    .vio_cnt0 (vio_cnt0),
    .vio_cnt1 (vio_cnt1),
    .phase    (phase),
    .ped_req  (ped_req),
    .ped_walk (ped_walk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase for a tick index: 9 green, 3 yellow, 1 red, 6 green, 3 yellow, 1 red.
  function automatic int ph(input int t);
    int m;
    m = t % 23;
    if (m < 9)       return 0;
    else if (m < 12) return 1;
    else if (m < 13) return 2;
    else if (m < 19) return 3;
    else if (m < 22) return 4;
    else             return 5;
  endfunction

  function automatic int mlamp(input int p);
    if (p == 0)      return 1;
    else if (p == 1) return 2;
    else             return 4;
  endfunction

  function automatic int slamp(input int p);
    if (p == 3)      return 1;
    else if (p == 4) return 2;
    else             return 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk with given inputs; checks phase and one-clk-late lamps.
  task automatic step(input logic tk, input logic [1:0] sv, input logic clr);
    e_prev  = ph(tcount);
    tick    = tk;
    s       = sv;
    vio_clr = clr;
    @(posedge clk);
    #1;
    if (tk) tcount++;
    chk("phase",   {29'd0, phase},   ph(tcount));
    chk("main_lt", {29'd0, main_lt}, mlamp(e_prev));
    chk("side_lt", {29'd0, side_lt}, slamp(e_prev));
  endtask

  task automatic chk_reset_vals();
    chk("rst_main_lt", {29'd0, main_lt}, 32'd1);
    chk("rst_side_lt", {29'd0, side_lt}, 32'd4);
    chk("rst_phase",   {29'd0, phase},   32'd0);
    chk("rst_camera",  {30'd0, camera},  32'd0);
    chk("rst_cnt0",    {28'd0, vio_cnt0}, 32'd0);
    chk("rst_cnt1",    {28'd0, vio_cnt1}, 32'd0);
    chk("rst_walk",    {31'd0, ped_walk}, 32'd0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    tick    = 1'b0;
    s       = 2'b00;
    vio_clr = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst    = 1'b0;
    tcount = 0;
  endtask

  initial begin
    // Full-rate ticks: two complete 23-tick cycles.
    do_reset();
    repeat (46) step(1'b1, 2'b00, 1'b0);

    // Tick every 4th clk: lengths scale, state holds between ticks.
    do_reset();
    for (int c = 0; c < 92; c++) step((c % 4) == 0, 2'b00, 1'b0);

    // Main violations during SIDE_G: single pulse even when held high.
    do_reset();
    repeat (13) step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b01, 1'b0);
    chk("cam_main_pulse", {30'd0, camera}, 32'd1);
    chk("cnt0_first",     {28'd0, vio_cnt0}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 2'b01, 1'b0);
      chk("cam_main_held", {30'd0, camera}, 32'd0);
      chk("cnt0_held",     {28'd0, vio_cnt0}, 32'd1);
    end
    step(1'b0, 2'b00, 1'b0);

    // Move to MAIN_Y: rising sensor under yellow is ignored.
    repeat (19) step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b01, 1'b0);
    chk("cam_main_yellow", {30'd0, camera}, 32'd0);
    chk("cnt0_yellow",     {28'd0, vio_cnt0}, 32'd1);
    step(1'b0, 2'b00, 1'b0);

    // Side is red here: 20 violations saturate at 15.
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 2'b10, 1'b0);
      chk("cam_side_pulse", {30'd0, camera}, 32'd2);
      chk("cnt1_sat",       {28'd0, vio_cnt1}, (n > 15) ? 32'd15 : n);
      step(1'b0, 2'b00, 1'b0);
      chk("cam_side_idle",  {30'd0, camera}, 32'd0);
    end

    // Clear coincident with a violation: counters zero, camera still fires.
    step(1'b0, 2'b10, 1'b1);
    chk("cam_clr",  {30'd0, camera},   32'd2);
    chk("cnt1_clr", {28'd0, vio_cnt1}, 32'd0);
    chk("cnt0_clr", {28'd0, vio_cnt0}, 32'd0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    chk("cnt1_after_clr", {28'd0, vio_cnt1}, 32'd1);
    step(1'b0, 2'b00, 1'b0);

    // Advance into SIDE_Y, then reset asynchronously between edges.
    repeat (10) step(1'b1, 2'b00, 1'b0);
    chk("in_side_y", {29'd0, phase}, 32'd4);
    rst = 1'b1;
    #2;
    chk_reset_vals();
    @(negedge clk);
    rst    = 1'b0;
    tcount = 0;
    repeat (25) step(1'b1, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
